// File: rtl/ibuffer_if.sv
// ibuffer_if: IFU -> ibuffer -> IDU signal bundle.
//   master : the IFU/IDU side that drives the instruction stream, pop and flush
//   slave  : the ibuffer itself
// Signals
//   flush_valid                 pipeline flush from writeback
//   ifu2ib_valid/ready          fetch-side push handshake
//   ifu2ib_inst/pc/predict*     fetched instruction and its prediction info
//   fifo_empty, ibuffer_*       head entry presented to the decoder
//   ibuffer_read_en             decoder accepts the head this cycle
interface ibuffer_if;
  logic        flush_valid;
  logic        ifu2ib_valid;
  logic        ifu2ib_ready;
  logic [31:0] ifu2ib_inst;
  logic [47:0] ifu2ib_pc;
  logic        ifu2ib_predicttaken;
  logic [31:0] ifu2ib_predicttarget;
  logic        fifo_empty;
  logic        ibuffer_instr_valid;
  logic [31:0] ibuffer_inst_out;
  logic [47:0] ibuffer_pc_out;
  logic        ibuffer_predicttaken_out;
  logic [31:0] ibuffer_predicttarget_out;
  logic        ibuffer_read_en;

  modport master (
    output flush_valid, ifu2ib_valid, ifu2ib_inst, ifu2ib_pc,
           ifu2ib_predicttaken, ifu2ib_predicttarget, ibuffer_read_en,
    input  ifu2ib_ready, fifo_empty, ibuffer_instr_valid, ibuffer_inst_out,
           ibuffer_pc_out, ibuffer_predicttaken_out, ibuffer_predicttarget_out
  );

  modport slave (
    input  flush_valid, ifu2ib_valid, ifu2ib_inst, ifu2ib_pc,
           ifu2ib_predicttaken, ifu2ib_predicttarget, ibuffer_read_en,
    output ifu2ib_ready, fifo_empty, ibuffer_instr_valid, ibuffer_inst_out,
           ibuffer_pc_out, ibuffer_predicttaken_out, ibuffer_predicttarget_out
  );
endinterface

// File: rtl/ibuffer.sv
// ibuffer: circular instruction FIFO between IFU and IDU. The head entry is shown
// first-word-fall-through and popped when the IDU asserts ibuffer_read_en.
// Ports
//   clock    core clock
//   reset_n  async active-low reset
//   ib       ibuffer_if.slave (push side, head outputs, pop, flush)
// Build option
//   IBUFFER_BYPASS_EN  when defined, an instruction arriving at an empty buffer is
//                      presented to the IDU in the same cycle; if consumed at once it
//                      is never written.
module ibuffer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic     clock,
  input  logic     reset_n,
  ibuffer_if.slave ib
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  typedef struct packed {
    logic [31:0] inst;
    logic [47:0] pc;
    logic        taken;
    logic [31:0] target;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  entry_t in_entry;
  entry_t head;
  logic   empty_q;
  logic   bypass;
  logic   head_valid;
  logic   ready;
  logic   push, pop;
  logic   do_write, do_read;

  always_comb begin
    in_entry = '{inst:   ib.ifu2ib_inst,
                 pc:     ib.ifu2ib_pc,
                 taken:  ib.ifu2ib_predicttaken,
                 target: ib.ifu2ib_predicttarget};

    empty_q = (count_q == '0);
    // Ready looks only at the registered count: a full buffer refuses a push even
    // when it is being popped in the same cycle.
    ready   = (count_q != FULL_CNT) & ~ib.flush_valid;

`ifdef IBUFFER_BYPASS_EN
    bypass = empty_q & ib.ifu2ib_valid & ~ib.flush_valid;
`else
    bypass = 1'b0;
`endif

    head_valid = ~empty_q | bypass;
    head       = '0;
    if (bypass)        head = in_entry;
    else if (!empty_q) head = mem_q[rd_ptr_q];

    push = ib.ifu2ib_valid & ready;
    pop  = ib.ibuffer_read_en & head_valid;

    // A bypassed entry consumed in the same cycle never touches the storage.
    do_write = push & ~(bypass & ib.ibuffer_read_en);
    do_read  = pop  & ~bypass;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ib.flush_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_read)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_write && !do_read)      count_d = count_q + CNT_ONE;
      else if (do_read && !do_write) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; the count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_write && !ib.flush_valid) mem_q[wr_ptr_q] <= in_entry;
  end

  assign ib.ifu2ib_ready              = ready;
  assign ib.ibuffer_instr_valid       = head_valid;
  assign ib.fifo_empty                = ~head_valid;
  assign ib.ibuffer_inst_out          = head.inst;
  assign ib.ibuffer_pc_out            = head.pc;
  assign ib.ibuffer_predicttaken_out  = head.taken;
  assign ib.ibuffer_predicttarget_out = head.target;

endmodule

// File: tb/tb_ibuffer.sv
// tb_ibuffer: directed scenarios plus randomized traffic, checked every cycle against
// a queue model of the instruction buffer.
module tb_ibuffer;
  localparam int DEPTH = 8;
`ifdef IBUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock;
  logic reset_n;
  ibuffer_if ib ();

  ibuffer dut (.clock(clock), .reset_n(reset_n), .ib(ib.slave));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // entry = {inst, pc, taken, target}
  logic [112:0] q [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit rd, input bit fl,
                       input logic [31:0] inst, input logic [47:0] pc);
    ib.ifu2ib_valid         = v;
    ib.ibuffer_read_en      = rd;
    ib.flush_valid          = fl;
    ib.ifu2ib_inst          = inst;
    ib.ifu2ib_pc            = pc;
    ib.ifu2ib_predicttaken  = inst[0];
    ib.ifu2ib_predicttarget = inst ^ 32'h5a5a_0000;
  endtask

  // One cycle: apply inputs, check outputs at negedge, advance model at posedge.
  task automatic step(input bit v, input bit rd, input bit fl,
                      input logic [31:0] inst, input logic [47:0] pc);
    logic [112:0] in_e, exp_head;
    bit exp_valid, exp_ready, byp;
    drive(v, rd, fl, inst, pc);
    in_e = {inst, pc, inst[0], inst ^ 32'h5a5a_0000};
    byp = BYP && (q.size() == 0) && v && !fl;
    exp_ready = (q.size() < DEPTH) && !fl;
    exp_valid = byp || (q.size() != 0);
    if (byp)                exp_head = in_e;
    else if (q.size() != 0) exp_head = q[0];
    else                    exp_head = '0;
    @(negedge clock);
    chk("ready", 128'(ib.ifu2ib_ready), 128'(exp_ready));
    chk("valid", 128'(ib.ibuffer_instr_valid), 128'(exp_valid));
    chk("empty", 128'(ib.fifo_empty), 128'(!exp_valid));
    chk("head", 128'({ib.ibuffer_inst_out, ib.ibuffer_pc_out, ib.ibuffer_predicttaken_out,
                      ib.ibuffer_predicttarget_out}), 128'(exp_head));
    @(posedge clock);
    if (fl) q.delete();
    else if (!(byp && rd)) begin
      if (rd && q.size() != 0) void'(q.pop_front());
      if (v && exp_ready) q.push_back(in_e);
    end
    #1;
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) step(1'b1, 1'b0, 1'b0, $urandom(), {16'($urandom()), $urandom()});
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;

    // Reset in the middle of traffic: outputs must clear without a clock edge.
    fill_to(3);
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_empty", 128'(ib.fifo_empty), 128'(1));
    chk("rst_valid", 128'(ib.ibuffer_instr_valid), 128'(0));
    chk("rst_ready", 128'(ib.ifu2ib_ready), 128'(1));
    chk("rst_data", 128'({ib.ibuffer_inst_out, ib.ibuffer_pc_out, ib.ibuffer_predicttaken_out,
                          ib.ibuffer_predicttarget_out}), 128'(0));
    q.delete();
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Fill with sequential PCs, then drain in order.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 32'h100 + i, 48'h1000 + 48'(4*i));
    step(1'b1, 1'b0, 1'b0, 32'hdead, 48'h9999);      // refused: full
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", 128'(ib.ibuffer_pc_out), 128'(48'h1000 + 48'(4*i)));
      step(1'b0, 1'b1, 1'b0, '0, '0);
    end
    step(1'b0, 1'b1, 1'b0, '0, '0);                  // pop while empty is ignored

    // Steady push+pop at count 3 across pointer wrap.
    fill_to(3);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h2000 + i, 48'h4000 + 48'(4*i));
    chk("wrap_cnt", 128'(q.size()), 128'(3));

    // Full buffer with a pop: push still refused.
    fill_to(DEPTH);
    step(1'b1, 1'b1, 1'b0, 32'hbeef, 48'h7777);
    chk("full_pop_cnt", 128'(q.size()), 128'(DEPTH - 1));

    // Flush with simultaneous push and pop, then first push lands at head.
    while (q.size() > 5) step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h1111, 48'h1111);
    step(1'b1, 1'b0, 1'b0, 32'h3333, 48'h3000);
    chk("post_flush_pc", 128'(ib.ibuffer_pc_out), 128'(48'h3000));
    step(1'b0, 1'b1, 1'b0, '0, '0);

    // Push into empty buffer; with read_en the bypassed entry is consumed outright.
    step(1'b1, 1'b0, 1'b0, 32'h0000_0013, 48'h2000);
    step(1'b0, 1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 32'h0000_0013, 48'h2000);
    step(1'b0, 1'b0, 1'b0, '0, '0);

    // Randomized traffic with varying push/pop pressure.
    for (int blk = 0; blk < 8; blk++) begin
      int rd_pct;
      int v_pct;
      rd_pct = $urandom_range(10, 90);
      v_pct  = $urandom_range(10, 90);
      for (int i = 0; i < 60; i++)
        step($urandom_range(0, 99) < v_pct, $urandom_range(0, 99) < rd_pct,
             $urandom_range(0, 40) == 0, $urandom(), {16'($urandom()), $urandom()});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
